// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake between uart_rx and its consumer
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8n1 UART receiver with selectable bit period and a one-byte holding register
module uart_rx #(
    parameter int SLOW_DIV = 1085,
    parameter int FAST_DIV = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        high_speed,
    uart_rx_if.master   out,
    output logic        frame_error,
    output logic        overflow
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int TW      = ($clog2(MAX_DIV) > 11) ? $clog2(MAX_DIV) : 11;

    localparam logic [TW-1:0] SLOW_HALF = TW'(SLOW_DIV / 2 - 1);
    localparam logic [TW-1:0] FAST_HALF = TW'(FAST_DIV / 2 - 1);
    localparam logic [TW-1:0] SLOW_PER  = TW'(SLOW_DIV - 1);
    localparam logic [TW-1:0] FAST_PER  = TW'(FAST_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rxs;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic            fast, fast_nxt;
    logic [7:0]      shreg;
    logic            shift_en;
    logic            byte_done;
    logic            ferr_nxt;
    logic [7:0]      hold_data;
    logic            hold_valid;
    logic [TW-1:0]   period;

    assign period = fast ? FAST_PER : SLOW_PER;

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = (tmr != '0) ? tmr - TW'(1) : tmr;
        bit_cnt_nxt = bit_cnt;
        fast_nxt    = fast;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    // Period is frozen here so a mid-frame high_speed change cannot skew sampling.
                    state_nxt = START;
                    fast_nxt  = high_speed;
                    tmr_nxt   = high_speed ? FAST_HALF : SLOW_HALF;
                end
            end
            START: begin
                if (tmr == '0) begin
                    if (rxs) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        tmr_nxt     = period;
                        bit_cnt_nxt = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tmr == '0) begin
                    shift_en = 1'b1;
                    tmr_nxt  = period;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tmr == '0) begin
                    if (rxs) begin
                        state_nxt = IDLE;
                        byte_done = 1'b1;
                    end else begin
                        state_nxt = WAIT_HIGH;
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= IDLE;
            tmr         <= '0;
            bit_cnt     <= 3'd0;
            fast        <= 1'b0;
            shreg       <= 8'h00;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
            hold_data   <= 8'h00;
            hold_valid  <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rxs         <= rx_meta;
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            fast        <= fast_nxt;
            frame_error <= ferr_nxt;
            overflow    <= byte_done && hold_valid && !out.ready;
            if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
            end
            // A finished byte may replace one that is being drained in the same cycle.
            if (byte_done && (!hold_valid || out.ready)) begin
                hold_data  <= shreg;
                hold_valid <= 1'b1;
            end else if (hold_valid && out.ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign out.data  = hold_data;
    assign out.valid = hold_valid;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int SLOW = 1085;
    localparam int FAST = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic high_speed = 1'b1;
    logic frame_error, overflow;

    uart_rx_if bus ();

    uart_rx #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .high_speed  (high_speed),
        .out         (bus.master),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    int both_cnt = 0;
    int exp_ferr = 0;
    int exp_ovf  = 0;

    always @(negedge clk) begin
        if (bus.valid && bus.ready) got_q.push_back(bus.data);
        if (frame_error) ferr_cnt++;
        if (overflow) ovf_cnt++;
        if (frame_error && overflow) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; drives start, 8 data bits LSB first, then the given stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(p);
        end
    endtask

    // Posedges from driving the start bit until valid is first seen high.
    task automatic measure(input logic [7:0] b, input int p, input int limit,
                           output int lat, output logic [7:0] d, output logic v_next);
        lat = 0; d = 8'h00; v_next = 1'b1;
        fork
            send_frame(b, 1'b1, p);
            begin
                logic seen;
                seen = 1'b0;
                while (!seen && lat < limit) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    if (bus.valid) begin
                        seen = 1'b1;
                        d = bus.data;
                    end
                end
                @(negedge clk);
                v_next = bus.valid;
            end
        join
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, gsz, fe0, ov0;
        logic [7:0] d;
        logic vn;

        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.valid, 0);
        check("rst_data", bus.data, 8'h00);
        check("rst_ferr", frame_error, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // 0xA5 at 4M baud: valid after 15+9*31+1 cycles plus 2 synchronizer cycles.
        measure(8'hA5, FAST, 400, lat, d, vn);
        exp_q.push_back(8'hA5);
        check("a5_latency", lat, 297);
        check("a5_data", d, 8'hA5);
        check("a5_one_cycle", vn, 0);
        idle(10);

        // False start: 10 low cycles is shorter than the half-bit sample point.
        gsz = got_q.size(); fe0 = ferr_cnt;
        rx = 1'b0; idle(10);
        rx = 1'b1; idle(40);
        check("false_start_nobyte", got_q.size(), gsz);
        check("false_start_noferr", ferr_cnt, fe0);
        send_frame(8'h3C, 1'b1, FAST); exp_q.push_back(8'h3C);
        idle(5);
        check("3c_rx", got_q.size(), gsz + 1);

        // Bad stop then a long break: exactly one frame error, no byte.
        gsz = got_q.size(); fe0 = ferr_cnt;
        send_frame(8'h55, 1'b0, FAST);
        idle(1000);
        rx = 1'b1; idle(2 * FAST);
        check("break_one_ferr", ferr_cnt, fe0 + 1);
        check("break_nobyte", got_q.size(), gsz);
        exp_ferr++;
        send_frame(8'h81, 1'b1, FAST); exp_q.push_back(8'h81);
        idle(5);
        check("81_rx", got_q.size(), gsz + 1);

        // Overflow: consumer stalled, second byte dropped.
        ov0 = ovf_cnt;
        bus.ready = 1'b0;
        send_frame(8'h11, 1'b1, FAST);
        send_frame(8'h22, 1'b1, FAST);
        idle(20);
        @(negedge clk);
        check("ovf_hold_valid", bus.valid, 1);
        check("ovf_hold_data", bus.data, 8'h11);
        check("ovf_pulses", ovf_cnt, ov0 + 1);
        exp_ovf++;
        @(posedge clk); #1;
        bus.ready = 1'b1;
        exp_q.push_back(8'h11);
        @(negedge clk);
        @(negedge clk);
        check("ovf_drained", bus.valid, 0);
        idle(5);

        // Reset during data bit 4 abandons the frame silently.
        gsz = got_q.size(); fe0 = ferr_cnt; ov0 = ovf_cnt;
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hC3, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = bits[i];
                idle(FAST);
            end
            rx = bits[5];
            idle(5);
        end
        rst = 1'b1; rx = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", bus.valid, 0);
        check("midrst_data", bus.data, 8'h00);
        idle(20 * FAST);
        check("midrst_nobyte", got_q.size(), gsz);
        check("midrst_noferr", ferr_cnt, fe0);
        check("midrst_noovf", ovf_cnt, ov0);
        send_frame(8'hC3, 1'b1, FAST); exp_q.push_back(8'hC3);
        idle(5);
        check("c3_rx", got_q.size(), gsz + 1);

        // 115200 baud: stop sample at 542+9*1085, valid one cycle later.
        high_speed = 1'b0;
        idle(5);
        measure(8'hFF, SLOW, 11000, lat, d, vn);
        exp_q.push_back(8'hFF);
        check("slow_ff_latency", lat, 542 + 9 * 1085 + 3);
        check("slow_ff_data", d, 8'hFF);
        send_frame(8'h00, 1'b1, SLOW); exp_q.push_back(8'h00);
        idle(5);
        high_speed = 1'b1;
        idle(5);

        // Random fast frames with random gaps and occasional bad stop bits.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic good;
            b = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, FAST);
            if (good) exp_q.push_back(b);
            else exp_ferr++;
            rx = 1'b1;
            idle($urandom_range(1, 40));
        end
        idle(10);

        check("total_bytes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("byte_%0d", i), got_q[i], exp_q[i]);
        check("total_ferr", ferr_cnt, exp_ferr);
        check("total_ovf", ovf_cnt, exp_ovf);
        check("ferr_ovf_same_cycle", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SLOW_DIV, default 1085, meaning the bit period in clk cycles at 115200 baud with a 125 MHz clk.
REQ-002 SHALL have parameter FAST_DIV, default 31, meaning the bit period in clk cycles at 4M baud (test mode).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, 8n1, idle high.
REQ-006 SHALL have port high_speed, input, 1 bit: 1 selects FAST_DIV, 0 selects SLOW_DIV.
REQ-007 SHALL have port data, output, 8 bits: received byte, valid while valid=1.
REQ-008 SHALL have port valid, output, 1 bit: the byte in data is available.
REQ-009 SHALL have port ready, input, 1 bit: the consumer accepts data; transfer occurs on a cycle where valid&&ready.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port overflow, output, 1 bit: one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); the FSM SHALL use only the synchronized signal rxs.
REQ-013 The FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 high_speed SHALL be latched on leaving IDLE; the bit period P (FAST_DIV or SLOW_DIV) SHALL stay fixed for the whole frame.
REQ-015 Cycle 0 is the first cycle in IDLE with rxs=0; the FSM SHALL enter START and sample rxs at cycle floor(P/2) (15 fast, 542 slow).
REQ-016 At the START sample: rxs=1 is a false start -> IDLE, with no output activity; rxs=0 -> DATA.
REQ-017 In DATA, the FSM SHALL sample bit i (i=0..7, LSB first) at cycle floor(P/2)+(i+1)*P, shifting it into an 8-bit shift register; after bit 7 it SHALL go to STOP.
REQ-018 In STOP, the FSM SHALL sample at cycle floor(P/2)+9*P.
REQ-019 Stop bit rxs=1 -> IDLE, and the byte SHALL be offered to the holding register on the next cycle.
REQ-020 Stop bit rxs=0 -> frame_error=1 for exactly one cycle, byte discarded, state WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL stay until rxs=1, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_error.
REQ-022 The bit timer SHALL be a down-counter at least 11 bits wide, loaded with (interval-1) and expiring at 0; no cumulative drift beyond integer truncation of P/2.
REQ-023 A byte SHALL appear in the holding register with valid=1 one cycle after the stop sample (cycle floor(P/2)+9*P+1), if the register is empty or being drained that cycle (valid&&ready).
REQ-024 If valid=1 and ready=0 when a new byte is offered, the new byte SHALL be dropped, data/valid SHALL stay unchanged, and overflow=1 for one cycle.
REQ-025 valid SHALL stay high and data stable until a cycle with ready=1; valid SHALL fall the next cycle unless a new byte is loaded that same cycle.
REQ-026 Reception SHALL be independent of ready; the FSM SHALL never stall.
REQ-027 frame_error and overflow SHALL never be asserted in the same cycle as each other for the same frame.

Reset
REQ-028 On rst=1 at a clk edge: state=IDLE, valid=0, data=8'h00, frame_error=0, overflow=0, shift register=0, timer=0, synchronizer flops=1.
REQ-029 Reset mid-frame SHALL abandon the frame with no valid, frame_error or overflow; the next falling edge after rst deasserts SHALL start a new frame.

Verification
REQ-030 high_speed=1, ready=1, send 0xA5 (P=31) -> valid=1, data=0xA5 at cycle 15+279+1=295 after rxs falls (+2 cycles from the rx pin), for one cycle.
REQ-031 rx low for 10 cycles then high, high_speed=1 -> no valid, no frame_error; a following 0x3C frame is received correctly.
REQ-032 Frame 0x55 with stop bit low, then rx held low 1000 cycles -> a single frame_error pulse, no valid; after rx returns high, 0x81 is received.
REQ-033 ready=0, two back-to-back frames 0x11 then 0x22 -> data=0x11 held with valid=1, one overflow pulse at the second byte; raising ready drains 0x11, then valid=0.
REQ-034 high_speed=0, send 0xFF and 0x00 at 115200 -> both received; the stop sample occurs at cycle 542+9*1085.
REQ-035 rst pulsed during DATA bit 4 -> outputs at reset values, no output pulses; the next full frame 0xC3 is received correctly.
